// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared NPC register-file definitions: hardwired-zero index, default widths
// and the helper that locates a port or register inside a flattened bus.
package regfile_mp_scoreboard_pkg;

    localparam int REG_ZERO           = 0;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Low bit of element idx in a bus built from equal slices of 'width' bits.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard_bits.sv
// Per-register busy scoreboard: completion clears, issue sets, flush wipes,
// plus the per-read-port hazard lookup.
module regfile_scoreboard_bits
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NWRITE-1:0]            wen,
    input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_rd,
    input  logic                         flush,
    input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
    input  logic [NREAD-1:0]             hit,
    output logic [(2**ADDR_WIDTH)-1:0]   busy_vec,
    output logic [NREAD-1:0]             rbusy
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_next;
    logic [ADDR_WIDTH-1:0] wa;
    logic [ADDR_WIDTH-1:0] ra;

    // Later rules win: a new producer overrides a same-cycle completion,
    // and flush overrides everything.
    always_comb begin
        busy_next = busy;
        wa        = '0;
        for (int j = 0; j < NWRITE; j++) begin
            wa = waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
            if (wen[j]) begin
                busy_next[wa] = 1'b0;
            end
        end
        if (iss_valid && (iss_rd != ZERO_IDX)) begin
            busy_next[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra       = raddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
            rbusy[i] = busy[ra] & (ra != ZERO_IDX) & ~hit[i];
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port NPC register file with x0 hardwired to zero, optional same-cycle
// write-to-read bypass, busy scoreboard and a flattened debug image.
module regfile_mp_scoreboard
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 1,
    parameter int BYPASS     = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREAD*ADDR_WIDTH-1:0]         raddr,
    output logic [NREAD*DATA_WIDTH-1:0]         rdata,
    output logic [NREAD-1:0]                    rbusy,
    input  logic [NWRITE-1:0]                   wen,
    input  logic [NWRITE*ADDR_WIDTH-1:0]        waddr,
    input  logic [NWRITE*DATA_WIDTH-1:0]        wdata,
    input  logic                                iss_valid,
    input  logic [ADDR_WIDTH-1:0]               iss_rd,
    input  logic                                flush,
    output logic [(2**ADDR_WIDTH)-1:0]          busy_vec,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] dbg_rf
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] rf [NREG];
    logic [NREAD-1:0]      hit;
    logic [ADDR_WIDTH-1:0] ra;
    logic [ADDR_WIDTH-1:0] wa;

    // Ports are visited in ascending order so the highest index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wen[j] && (waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] != ZERO_IDX)) begin
                    rf[waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH]] <=
                        wdata[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        hit   = '0;
        ra    = '0;
        wa    = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = raddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
            rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rf[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    wa = waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
                    if (wen[j] && (wa == ra)) begin
                        hit[i] = 1'b1;
                        rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
                            wdata[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
            end
            // x0 never forwards, so a write of x0 cannot leak into a read.
            if (ra == ZERO_IDX) begin
                hit[i] = 1'b0;
                rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = '0;
            end
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_dbg
        assign dbg_rf[slice_lo(r, DATA_WIDTH) +: DATA_WIDTH] = rf[r];
    end

    regfile_scoreboard_bits #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NREAD      (NREAD),
        .NWRITE     (NWRITE)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (wen),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .raddr     (raddr),
        .hit       (hit),
        .busy_vec  (busy_vec),
        .rbusy     (rbusy)
    );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench: a bypassing dual-write instance driven from a vector table,
// plus a non-bypassing single-write instance and async-reset sequences.
module tb_regfile_mp_scoreboard;

    logic clk;
    logic rst_n;

    // Instance A: NREAD=2, NWRITE=2, BYPASS=1
    logic [9:0]    raddr_a;
    logic [63:0]   rdata_a;
    logic [1:0]    rbusy_a;
    logic [1:0]    wen_a;
    logic [9:0]    waddr_a;
    logic [63:0]   wdata_a;
    logic          iss_valid_a;
    logic [4:0]    iss_rd_a;
    logic          flush_a;
    logic [31:0]   busy_vec_a;
    logic [1023:0] dbg_rf_a;

    // Instance B: NREAD=2, NWRITE=1, BYPASS=0
    logic [9:0]    raddr_b;
    logic [63:0]   rdata_b;
    logic [1:0]    rbusy_b;
    logic [0:0]    wen_b;
    logic [4:0]    waddr_b;
    logic [31:0]   wdata_b;
    logic          iss_valid_b;
    logic [4:0]    iss_rd_b;
    logic          flush_b;
    logic [31:0]   busy_vec_b;
    logic [1023:0] dbg_rf_b;

    int checks = 0;
    int errors = 0;

    regfile_mp_scoreboard #(.NREAD(2), .NWRITE(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .iss_valid(iss_valid_a),
        .iss_rd(iss_rd_a), .flush(flush_a), .busy_vec(busy_vec_a), .dbg_rf(dbg_rf_a)
    );

    regfile_mp_scoreboard #(.NREAD(2), .NWRITE(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .iss_valid(iss_valid_b),
        .iss_rd(iss_rd_b), .flush(flush_b), .busy_vec(busy_vec_b), .dbg_rf(dbg_rf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rbusy;
        logic [31:0] e_busy;
        logic [4:0]  chk_reg;
        logic [31:0] e_reg;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wen_a       = v.wen;
        waddr_a     = {v.wa1, v.wa0};
        wdata_a     = {v.wd1, v.wd0};
        iss_valid_a = v.iv;
        iss_rd_a    = v.ird;
        flush_a     = v.fl;
        raddr_a     = {v.ra1, v.ra0};
    endtask

    task automatic idleA();
        wen_a = '0; waddr_a = '0; wdata_a = '0;
        iss_valid_a = 1'b0; iss_rd_a = '0; flush_a = 1'b0; raddr_a = '0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- table contents ----------------
        vecs[0]  = '{2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0,
                     32'hA5A5A5A5, 32'h0, 2'b00, 32'h0, 5'd3, 32'hA5A5A5A5};
        vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0,
                     32'hA5A5A5A5, 32'h0, 2'b00, 32'h0, 5'd3, 32'hA5A5A5A5};
        vecs[2]  = '{2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3,
                     32'h2, 32'hA5A5A5A5, 2'b00, 32'h0, 5'd7, 32'h2};
        vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd7, 5'd9,
                     32'h2, 32'h0, 2'b00, 32'h200, 5'd7, 32'h2};
        vecs[4]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd7,
                     32'h0, 32'h2, 2'b01, 32'h200, 5'd9, 32'h0};
        vecs[5]  = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd3,
                     32'h99, 32'hA5A5A5A5, 2'b00, 32'h0, 5'd9, 32'h99};
        vecs[6]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0,
                     32'h55, 32'h0, 2'b00, 32'h200, 5'd9, 32'h55};
        vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd9, 5'd7,
                     32'h55, 32'h2, 2'b01, 32'h210, 5'd9, 32'h55};
        vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd4, 5'd6,
                     32'h0, 32'h0, 2'b01, 32'h250, 5'd4, 32'h0};
        vecs[9]  = '{2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd6, 5'd4,
                     32'h66, 32'h0, 2'b10, 32'h0, 5'd6, 32'h66};
        vecs[10] = '{2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd6,
                     32'h0, 32'h66, 2'b00, 32'h0, 5'd0, 32'h0};
        vecs[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4,
                     32'h0, 32'h0, 2'b00, 32'h0, 5'd6, 32'h66};

        // ---------------- power-on reset ----------------
        rst_n = 1'b0;
        idleA();
        wen_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
        iss_valid_b = 1'b0; iss_rd_b = '0; flush_b = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("por busy_vec", 64'(busy_vec_a), 64'h0);
        checkOutput("por dbg_rf nonzero", 64'(|dbg_rf_a), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();

        // ---------------- async reset mid-operation ----------------
        wen_a = 2'b01; waddr_a = {5'd0, 5'd5}; wdata_a = {32'h0, 32'h1234};
        iss_valid_a = 1'b1; iss_rd_a = 5'd5;
        stepCycle();
        idleA();
        raddr_a = {5'd0, 5'd5};
        #1;
        checkOutput("pre-reset rdata0", 64'(rdata_a[31:0]), 64'h1234);
        checkOutput("pre-reset busy_vec", 64'(busy_vec_a), 64'h20);
        checkOutput("pre-reset rbusy", 64'(rbusy_a), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("async rst rdata0", 64'(rdata_a[31:0]), 64'h0);
        checkOutput("async rst busy_vec", 64'(busy_vec_a), 64'h0);
        checkOutput("async rst rbusy", 64'(rbusy_a), 64'h0);
        checkOutput("async rst dbg x5", 64'(dbg_rf_a[5*32 +: 32]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        raddr_a = '0;
        stepCycle();

        // ---------------- table-driven vectors on instance A ----------------
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("v%0d rdata0", i), 64'(rdata_a[31:0]), 64'(vecs[i].e_rd0));
            checkOutput($sformatf("v%0d rdata1", i), 64'(rdata_a[63:32]), 64'(vecs[i].e_rd1));
            checkOutput($sformatf("v%0d rbusy", i), 64'(rbusy_a), 64'(vecs[i].e_rbusy));
            stepCycle();
            checkOutput($sformatf("v%0d busy_vec", i), 64'(busy_vec_a), 64'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d dbg_rf[x%0d]", i, vecs[i].chk_reg),
                        64'(dbg_rf_a[32*int'(vecs[i].chk_reg) +: 32]), 64'(vecs[i].e_reg));
        end
        idleA();

        // ---------------- BYPASS=0 instance B ----------------
        wen_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h11;
        stepCycle();
        wdata_b = 32'hA5A5A5A5;
        raddr_b = {5'd0, 5'd3};
        #1;
        checkOutput("nobyp same-cycle rdata0", 64'(rdata_b[31:0]), 64'h11);
        stepCycle();
        wen_b = 1'b0;
        #1;
        checkOutput("nobyp next-cycle rdata0", 64'(rdata_b[31:0]), 64'hA5A5A5A5);
        wen_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hDEADBEEF;
        raddr_b = {5'd3, 5'd0};
        #1;
        checkOutput("nobyp x0 rdata0", 64'(rdata_b[31:0]), 64'h0);
        stepCycle();
        wen_b = 1'b0;
        #1;
        checkOutput("nobyp dbg x0", 64'(dbg_rf_b[31:0]), 64'h0);
        checkOutput("nobyp rdata1 x3", 64'(rdata_b[63:32]), 64'hA5A5A5A5);
        checkOutput("nobyp busy_vec", 64'(busy_vec_b), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Next-generation NPC general-purpose register file, parametrised in read-port count, write-port count, width and depth.
- Adds same-cycle write-to-read bypass, async active-low reset of all registers, and a per-register busy scoreboard for pipelined issue/writeback hazard detection.
- Sits between the decode/issue stage (reads, issue marks) and the writeback stage (writes); a flattened register image is exported for waveform and difftest use.

Parameters:
- ADDR_WIDTH, 5, register index width; depth NREG = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NREAD, 2, number of read ports (>=1).
- NWRITE, 1, number of write ports (>=1).
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = reads return the pre-write value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  async active-low reset.
- raddr  in  NREAD*ADDR_WIDTH  read addresses; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NREAD*DATA_WIDTH  read data, combinational.
- rbusy  out  NREAD  per-port hazard flag, combinational.
- wen  in  NWRITE  write enables.
- waddr  in  NWRITE*ADDR_WIDTH  write addresses.
- wdata  in  NWRITE*DATA_WIDTH  write data.
- iss_valid  in  1  issue of an instruction with a destination register.
- iss_rd  in  ADDR_WIDTH  destination register of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits.
- busy_vec  out  NREG  current scoreboard bits, registered.
- dbg_rf  out  NREG*DATA_WIDTH  flattened register image; register r occupies [r*DATA_WIDTH +: DATA_WIDTH], registered.

Behaviour:
- Reset: rst_n low asynchronously clears every register and every busy bit to 0. Consequently rdata, rbusy, busy_vec and dbg_rf are all 0 while reset is held. Release is synchronised externally.
- Register 0 is hardwired to 0:
  - writes to x0 are dropped;
  - reads of x0 return 0, with no bypass;
  - busy[0] is never set and reads as 0.
- Write: on each rising edge, every port j with wen[j]=1 and waddr!=0 updates rf[waddr] <= wdata.
- Write collisions: when several ports target the same address in one cycle, the highest port index wins.
- Read latency is 0 (combinational):
  - BYPASS=1: if any enabled write port targets raddr_i (raddr_i != 0), rdata_i = wdata of the highest-index such port; otherwise rf[raddr_i].
  - BYPASS=0: rdata_i = rf[raddr_i] always.
- Scoreboard update each edge, in priority order low to high (later rules override earlier ones):
  - clear: busy[waddr_j] <= 0 for each enabled write j;
  - set: busy[iss_rd] <= 1 if iss_valid and iss_rd != 0;
  - flush: flush=1 clears all busy bits regardless of issue or write.
- Net effect: same-cycle issue and writeback to the same register leaves busy=1, because a new producer overrides the old completion. Flush overrides both.
- rbusy_i = busy[raddr_i] & (raddr_i != 0) & ~hit_i, where hit_i = (BYPASS=1 and some enabled write targets raddr_i this cycle). A value being written back is therefore not a hazard when bypass is on.
- busy_vec and dbg_rf reflect state after the last edge; they exclude the current cycle's writes.
- Reset mid-operation: pending writes and issues in that cycle are discarded; all state is 0 on release.
- No X propagation: all outputs are defined for any raddr value, since depth is exactly 2**ADDR_WIDTH.

Decomposition:
- Shared NPC package holds:
  - constants REG_ZERO=0 and the default ADDR_WIDTH/DATA_WIDTH;
  - a function for flattened-slice offsets.
- One natural sub-module: regfile_scoreboard_bits, which holds the busy vector with its set/clear/flush priority logic and the rbusy lookup.
- Storage, write arbitration and bypass muxing stay in the top module.

Test Plan:
- Reset, bypass and x0: assert rst_n=0 after writing rf[5]=0x1234 -> rdata=0 and busy_vec=0 immediately, without waiting for a clock edge. Then write waddr=0 with wdata=0xDEADBEEF -> reading x0 returns 0, including in the same cycle with BYPASS=1.
- Write then read, BYPASS=1: wen=1, waddr=3, wdata=0xA5A5A5A5 with raddr0=3 in the same cycle -> rdata0=0xA5A5A5A5 combinationally, and dbg_rf slot 3 updates after the edge.
- BYPASS=0 instance, same stimulus after rf[3]=0x11 -> rdata0=0x11 in that cycle and 0xA5A5A5A5 in the next cycle.
- Dual write collision (NWRITE=2): both ports write x7, port0=0x1, port1=0x2 -> rf[7]=0x2 after the edge, and the bypassed read in that cycle also returns 0x2.
- Scoreboard: iss_valid with iss_rd=9 -> next cycle busy_vec[9]=1 and rbusy=1 for raddr=9. Then writeback to x9 -> rbusy=0 in the same cycle (bypass) and busy[9]=0 after the edge. Simultaneous issue and writeback to x9 -> busy[9] remains 1.
- Flush priority: busy bits 4 and 6 set, then flush=1 together with iss_valid, iss_rd=4 -> busy_vec=0 after the edge. Issue to x0 -> busy_vec stays 0.
